pad_mux_ctrl: RTL and testbench



---
 rtl/pad_mux_pkg.sv | 47 ++++
 rtl/pad_in_filter.sv | 51 +++++
 rtl/pad_mux_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pad_mux_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_mux_pkg.sv
// Shared constants and types for the pad multiplexer controller: CFG field
// positions, function codes, interrupt modes and register addresses.
package pad_mux_pkg;

   // CFG register field positions
   localparam int CFG_FUNC_LSB = 0;
   localparam int CFG_GPO      = 2;
   localparam int CFG_GPOE     = 3;
   localparam int CFG_CS       = 4;
   localparam int CFG_SL       = 5;
   localparam int CFG_PU       = 6;
   localparam int CFG_PD       = 7;
   localparam int CFG_IRQ_LSB  = 8;
   localparam int CFG_DB_LSB   = 12;

   // Bits of a CFG register that hold state; every other bit reads back 0
   localparam logic [15:0] CFG_RW_MASK = 16'hF3FF;

   // Function code 0 always routes the pad to the GPIO bits of CFG
   localparam logic [1:0] FUNC_GPIO = 2'd0;

   // Edge-detect interrupt mode per pad
   typedef enum logic [1:0] {
      IRQ_OFF  = 2'd0,
      IRQ_RISE = 2'd1,
      IRQ_FALL = 2'd2,
      IRQ_BOTH = 2'd3
   } irq_mode_e;

   // Byte addresses of the non-CFG registers
   localparam logic [7:0] ADDR_IN   = 8'h80;
   localparam logic [7:0] ADDR_PEND = 8'h84;

   // Decide whether a filtered edge should raise the pad's pending bit
   function automatic logic irq_hit(irq_mode_e mode, logic rise, logic fall);
      logic hit;
      hit = 1'b0;
      case (mode)
         IRQ_OFF:  hit = 1'b0;
         IRQ_RISE: hit = rise;
         IRQ_FALL: hit = fall;
         IRQ_BOTH: hit = rise | fall;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/pad_in_filter.sv
// Per-pad input conditioning: two-flop synchroniser, debounce counter and
// the filtered level, plus single-cycle rise/fall strobes on filter updates.
module pad_in_filter #(
   parameter int DB_W = 8
) (
   input  logic       clk_i,
   input  logic       rst_in,
   input  logic       pad_i,
   input  logic [3:0] db_i,
   output logic       filt_o,
   output logic       rise_o,
   output logic       fall_o
);

   logic [1:0]      sync_q;
   logic [DB_W-1:0] cnt_q;
   logic [DB_W-1:0] thresh;
   logic            filt_q;
   logic            differ;
   logic            update;

   // The debounce threshold scales the 4-bit setting into the top of the counter range
   assign thresh = DB_W'(db_i) << (DB_W - 4);
   assign differ = sync_q[1] != filt_q;
   assign update = differ && (cnt_q >= thresh);

   // Edges are reported on the same clock edge that the filtered level changes
   assign rise_o = update & sync_q[1];
   assign fall_o = update & ~sync_q[1];
   assign filt_o = filt_q;

   // Synchronise the raw pad, count how long it has disagreed with the filtered level, and adopt it once the count reaches the threshold
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pad_i};
         if (!differ) begin
            cnt_q <= '0;
         end else if (cnt_q != {DB_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (update) begin
            filt_q <= sync_q[1];
         end
      end
   end

endmodule

// File: rtl/pad_mux_ctrl.sv
// Register-programmable pad controller: per-pad function select between GPIO
// and alternate peripherals, electrical config, filtered inputs and edge
// interrupts, all programmed over a Wishbone classic slave.
module pad_mux_ctrl
   import pad_mux_pkg::*;
#(
   parameter int NUM_PADS = 8,
   parameter int NUM_ALT  = 3,
   parameter int DB_W     = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_in,
   input  logic [7:0]                  wb_adr_i,
   input  logic [31:0]                 wb_dat_i,
   output logic [31:0]                 wb_dat_o,
   input  logic                        wb_we_i,
   input  logic [3:0]                  wb_sel_i,
   input  logic                        wb_stb_i,
   input  logic                        wb_cyc_i,
   output logic                        wb_ack_o,
   input  logic [NUM_PADS*NUM_ALT-1:0] alt_out_i,
   input  logic [NUM_PADS*NUM_ALT-1:0] alt_oe_i,
   input  logic [NUM_PADS-1:0]         pad_in_i,
   output logic [NUM_PADS-1:0]         pad_out_o,
   output logic [NUM_PADS-1:0]         pad_oe_o,
   output logic [NUM_PADS-1:0]         pad_ie_o,
   output logic [NUM_PADS-1:0]         pad_cs_o,
   output logic [NUM_PADS-1:0]         pad_sl_o,
   output logic [NUM_PADS-1:0]         pad_pu_o,
   output logic [NUM_PADS-1:0]         pad_pd_o,
   output logic [NUM_PADS-1:0]         in_filt_o,
   output logic                        irq_o
);

   logic [15:0]         cfg_q [NUM_PADS];
   logic [NUM_PADS-1:0] pend_q;
   logic [NUM_PADS-1:0] pend_set;
   logic [NUM_PADS-1:0] pend_clr;
   logic [NUM_PADS-1:0] filt;
   logic [NUM_PADS-1:0] rise;
   logic [NUM_PADS-1:0] fall;
   logic [31:0]         wr_mask;
   logic [31:0]         wr_bits;
   logic [31:0]         rd_data;
   logic [5:0]          word;
   logic                wb_req;
   logic                wr_en;
   logic                unused_bits;

   assign wb_req  = wb_stb_i & wb_cyc_i;
   assign word    = wb_adr_i[7:2];
   assign wr_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign wr_bits = wb_dat_i & wr_mask;

   // A write lands on the clock edge that closes its ack cycle, so a reset during the transfer loses it
   assign wr_en = wb_ack_o & wb_req & wb_we_i;

   assign pend_clr = (wr_en && word == ADDR_PEND[7:2]) ? wr_bits[NUM_PADS-1:0] : '0;

   assign unused_bits = ^{wb_adr_i[1:0], wr_bits};

   // Byte-lane write of the addressed CFG register, keeping only the defined fields
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            cfg_q[i] <= '0;
         end
      end else if (wr_en) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            if (word == 6'(i)) begin
               cfg_q[i] <= (cfg_q[i] & ~wr_mask[15:0]) | (wr_bits[15:0] & CFG_RW_MASK);
            end
         end
      end
   end

   // Read mux; anything not decoded returns zero
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (word == 6'(i)) begin
            rd_data = {16'h0000, cfg_q[i]};
         end
      end
      if (word == ADDR_IN[7:2]) begin
         rd_data[NUM_PADS-1:0] = filt;
      end
      if (word == ADDR_PEND[7:2]) begin
         rd_data[NUM_PADS-1:0] = pend_q;
      end
   end

   // Single-cycle ack one cycle after the request; a held strobe is answered every other cycle
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= wb_req & ~wb_ack_o;
         wb_dat_o <= (wb_req & ~wb_ack_o) ? rd_data : '0;
      end
   end

   // Pending bits: new edges win over a write-one-to-clear in the same cycle
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~pend_clr) | pend_set;
      end
   end

   // Interrupt line follows the pending register one cycle later
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         irq_o <= 1'b0;
      end else begin
         irq_o <= |pend_q;
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      logic [1:0] func;
      logic       use_alt;
      logic       alt_out;
      logic       alt_oe;
      logic       oe;

      assign func = cfg_q[p][CFG_FUNC_LSB +: 2];

      // Select the alternate function named by func; codes beyond NUM_ALT fall back to GPIO
      always_comb begin
         use_alt = 1'b0;
         alt_out = 1'b0;
         alt_oe  = 1'b0;
         for (int k = 1; k <= NUM_ALT; k++) begin
            if (func != FUNC_GPIO && func == 2'(k)) begin
               use_alt = 1'b1;
               alt_out = alt_out_i[p*NUM_ALT + k - 1];
               alt_oe  = alt_oe_i[p*NUM_ALT + k - 1];
            end
         end
      end

      assign oe           = use_alt ? alt_oe : cfg_q[p][CFG_GPOE];
      assign pad_out_o[p] = use_alt ? alt_out : cfg_q[p][CFG_GPO];
      assign pad_oe_o[p]  = oe;
      assign pad_ie_o[p]  = ~oe;
      assign pad_cs_o[p]  = cfg_q[p][CFG_CS];
      assign pad_sl_o[p]  = cfg_q[p][CFG_SL];
      assign pad_pu_o[p]  = cfg_q[p][CFG_PU];
      assign pad_pd_o[p]  = cfg_q[p][CFG_PD];

      pad_in_filter #(
         .DB_W (DB_W)
      ) u_filter (
         .clk_i  (clk_i),
         .rst_in (rst_in),
         .pad_i  (pad_in_i[p]),
         .db_i   (cfg_q[p][CFG_DB_LSB +: 4]),
         .filt_o (filt[p]),
         .rise_o (rise[p]),
         .fall_o (fall[p])
      );

      assign pend_set[p] = irq_hit(irq_mode_e'(cfg_q[p][CFG_IRQ_LSB +: 2]), rise[p], fall[p]);
   end

   assign in_filt_o = filt;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Testbench for pad_mux_ctrl: directed register/pad scenarios followed by
// randomised configuration and pad activity, compared against a behavioural
// model of the register map, pad routing and debounce rules.
module tb_pad_mux_ctrl;

   localparam int NP  = 8;
   localparam int NA  = 2;
   localparam int DBW = 8;

   logic             clk_i;
   logic             rst_in;
   logic [7:0]       wb_adr_i;
   logic [31:0]      wb_dat_i;
   logic [31:0]      wb_dat_o;
   logic             wb_we_i;
   logic [3:0]       wb_sel_i;
   logic             wb_stb_i;
   logic             wb_cyc_i;
   logic             wb_ack_o;
   logic [NP*NA-1:0] alt_out_i;
   logic [NP*NA-1:0] alt_oe_i;
   logic [NP-1:0]    pad_in_i;
   logic [NP-1:0]    pad_out_o;
   logic [NP-1:0]    pad_oe_o;
   logic [NP-1:0]    pad_ie_o;
   logic [NP-1:0]    pad_cs_o;
   logic [NP-1:0]    pad_sl_o;
   logic [NP-1:0]    pad_pu_o;
   logic [NP-1:0]    pad_pd_o;
   logic [NP-1:0]    in_filt_o;
   logic             irq_o;

   int totalCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   // Reference model state
   logic [15:0]   mCfg [NP];
   int            mAge [NP];
   logic [NP-1:0] mS1, mS2, mFilt, mPend;
   logic          mIrq;
   logic          mWrValid;
   logic [7:0]    mWrAdr;
   logic [31:0]   mWrDat;
   logic [3:0]    mWrSel;

   pad_mux_ctrl #(
      .NUM_PADS (NP),
      .NUM_ALT  (NA),
      .DB_W     (DBW)
   ) dut (
      .clk_i     (clk_i),
      .rst_in    (rst_in),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_dat_o  (wb_dat_o),
      .wb_we_i   (wb_we_i),
      .wb_sel_i  (wb_sel_i),
      .wb_stb_i  (wb_stb_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_ack_o  (wb_ack_o),
      .alt_out_i (alt_out_i),
      .alt_oe_i  (alt_oe_i),
      .pad_in_i  (pad_in_i),
      .pad_out_o (pad_out_o),
      .pad_oe_o  (pad_oe_o),
      .pad_ie_o  (pad_ie_o),
      .pad_cs_o  (pad_cs_o),
      .pad_sl_o  (pad_sl_o),
      .pad_pu_o  (pad_pu_o),
      .pad_pd_o  (pad_pd_o),
      .in_filt_o (in_filt_o),
      .irq_o     (irq_o)
   );

   // 10 ns clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Behavioural model: a pad's filtered level flips once its synchronised input has disagreed for 16*db+1 consecutive cycles
   always @(posedge clk_i or negedge rst_in) begin : refModel
      logic [NP-1:0] setBits;
      logic [NP-1:0] clrBits;
      logic [31:0]   laneMask;
      int            thr;
      int            idx;
      if (!rst_in) begin
         for (int p = 0; p < NP; p++) begin
            mCfg[p] = '0;
            mAge[p] = 0;
         end
         mS1   = '0;
         mS2   = '0;
         mFilt = '0;
         mPend = '0;
         mIrq  = 1'b0;
      end else begin
         mIrq    = |mPend;
         setBits = '0;
         clrBits = '0;
         for (int p = 0; p < NP; p++) begin
            thr = int'(mCfg[p][15:12]) * 16;
            if (mS2[p] != mFilt[p]) begin
               if (mAge[p] >= thr) begin
                  mFilt[p] = mS2[p];
                  if (mS2[p] ? mCfg[p][8] : mCfg[p][9]) setBits[p] = 1'b1;
               end
               if (mAge[p] < 255) mAge[p] = mAge[p] + 1;
            end else begin
               mAge[p] = 0;
            end
         end
         mS2 = mS1;
         mS1 = pad_in_i;
         if (mWrValid) begin
            laneMask = {{8{mWrSel[3]}}, {8{mWrSel[2]}}, {8{mWrSel[1]}}, {8{mWrSel[0]}}};
            idx = int'(mWrAdr) / 4;
            if (idx < NP) begin
               mCfg[idx] = (mCfg[idx] & ~laneMask[15:0]) | (mWrDat[15:0] & laneMask[15:0] & 16'hF3FF);
            end else if (mWrAdr == 8'h84) begin
               clrBits = mWrDat[NP-1:0] & laneMask[NP-1:0];
            end
         end
         mPend = (mPend & ~clrBits) | setBits;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Expected pad control words from the model's CFG and the live alternate inputs
   task automatic expPads(output logic [31:0] ctlA, output logic [31:0] ctlB);
      logic [NP-1:0] o, e, cs, sl, pu, pd;
      int f;
      for (int p = 0; p < NP; p++) begin
         f = int'(mCfg[p][1:0]);
         if (f >= 1 && f <= NA) begin
            o[p] = alt_out_i[p*NA + f - 1];
            e[p] = alt_oe_i[p*NA + f - 1];
         end else begin
            o[p] = mCfg[p][2];
            e[p] = mCfg[p][3];
         end
         cs[p] = mCfg[p][4];
         sl[p] = mCfg[p][5];
         pu[p] = mCfg[p][6];
         pd[p] = mCfg[p][7];
      end
      ctlA = {cs, ~e, e, o};
      ctlB = {mFilt, pd, pu, sl};
   endtask

   task automatic checkModel(input string tag);
      logic [31:0] ea, eb;
      expPads(ea, eb);
      checkOutput({tag, "/padA"}, {pad_cs_o, pad_ie_o, pad_oe_o, pad_out_o}, ea);
      checkOutput({tag, "/padB"}, {in_filt_o, pad_pd_o, pad_pu_o, pad_sl_o}, eb);
      checkOutput({tag, "/irq"}, {31'd0, irq_o}, {31'd0, mIrq});
   endtask

   task automatic applyStimulus(input logic [NP-1:0] pads);
      @(negedge clk_i);
      pad_in_i = pads;
   endtask

   task automatic wbWrite(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      @(negedge clk_i);
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      wb_we_i  = 1'b1;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      @(negedge clk_i);
      checkOutput("wr_ack", {31'd0, wb_ack_o}, 32'd1);
      mWrAdr   = adr;
      mWrDat   = dat;
      mWrSel   = sel;
      mWrValid = 1'b1;
      @(negedge clk_i);
      mWrValid = 1'b0;
      checkOutput("wr_ack_gap", {31'd0, wb_ack_o}, 32'd0);
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic wbRead(input logic [7:0] adr, output logic [31:0] dat);
      @(negedge clk_i);
      wb_adr_i = adr;
      wb_sel_i = 4'hF;
      wb_we_i  = 1'b0;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      @(negedge clk_i);
      checkOutput("rd_ack", {31'd0, wb_ack_o}, 32'd1);
      dat      = wb_dat_o;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [NP-1:0] flip;
      rst_in    = 1'b0;
      mWrValid  = 1'b0;
      mWrAdr    = '0;
      mWrDat    = '0;
      mWrSel    = '0;
      wb_adr_i  = '0;
      wb_dat_i  = '0;
      wb_we_i   = 1'b0;
      wb_sel_i  = '0;
      wb_stb_i  = 1'b0;
      wb_cyc_i  = 1'b0;
      alt_out_i = '0;
      alt_oe_i  = '0;
      pad_in_i  = '0;
      repeat (3) @(negedge clk_i);
      rst_in = 1'b1;
      @(negedge clk_i);

      // Reset state
      checkOutput("rst_pads", {pad_cs_o, pad_ie_o, pad_oe_o, pad_out_o}, 32'h00FF_0000);
      checkOutput("rst_irq_ack", {30'd0, irq_o, wb_ack_o}, 32'd0);
      wbRead(8'h00, rd);
      checkOutput("rst_cfg0", rd, 32'd0);
      wbRead(8'h80, rd);
      checkOutput("rst_in", rd, 32'd0);
      wbRead(8'h84, rd);
      checkOutput("rst_pend", rd, 32'd0);
      checkModel("rst");

      // GPIO drive on pad 2, then a byte-0-only write
      wbWrite(8'h08, 32'h0000_000C, 4'hF);
      checkOutput("gpo_pad2", {29'd0, pad_ie_o[2], pad_oe_o[2], pad_out_o[2]}, 32'b011);
      wbRead(8'h08, rd);
      checkOutput("gpo_readback", rd, 32'h0000_000C);
      wbWrite(8'h08, 32'hFFFF_FFFF, 4'b0001);
      wbRead(8'h08, rd);
      checkOutput("sel_readback", rd, 32'h0000_00FF);
      checkOutput("func3_pad2", {25'd0, pad_pd_o[2], pad_pu_o[2], pad_sl_o[2], pad_cs_o[2],
                                 pad_ie_o[2], pad_oe_o[2], pad_out_o[2]}, 32'b1111011);
      checkModel("gpio");

      // Alternate function 2 on pad 1, then an out-of-range function code
      alt_out_i[3] = 1'b1;
      alt_oe_i[3]  = 1'b1;
      wbWrite(8'h04, 32'h0000_0002, 4'hF);
      checkOutput("alt2_pad1", {29'd0, pad_ie_o[1], pad_oe_o[1], pad_out_o[1]}, 32'b011);
      wbWrite(8'h04, 32'h0000_000B, 4'hF);
      checkOutput("func3_pad1", {29'd0, pad_ie_o[1], pad_oe_o[1], pad_out_o[1]}, 32'b010);
      checkModel("alt");

      // Rise interrupt on pad 0 with no debounce
      wbWrite(8'h00, 32'h0000_0100, 4'hF);
      applyStimulus(pad_in_i | 8'h01);
      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("db0_edge2", {31'd0, in_filt_o[0]}, 32'd0);
      @(negedge clk_i);
      checkOutput("db0_edge3", {30'd0, irq_o, in_filt_o[0]}, 32'b01);
      @(negedge clk_i);
      checkOutput("irq_late", {31'd0, irq_o}, 32'd1);
      checkModel("rise0");
      wbRead(8'h84, rd);
      checkOutput("pend0", rd, 32'h01);
      wbRead(8'h80, rd);
      checkOutput("in0", rd, 32'h01);
      wbWrite(8'h84, 32'h1, 4'hF);
      @(negedge clk_i);
      checkOutput("irq_cleared", {31'd0, irq_o}, 32'd0);

      // Debounce on pad 4: short glitch rejected, long level accepted
      wbWrite(8'h10, 32'h0000_2100, 4'hF);
      applyStimulus(pad_in_i | 8'h10);
      for (int c = 0; c < 19; c++) begin
         @(negedge clk_i);
         checkModel("glitch");
      end
      applyStimulus(pad_in_i & 8'hEF);
      repeat (40) @(negedge clk_i);
      wbRead(8'h80, rd);
      checkOutput("glitch_in", rd, 32'h01);
      wbRead(8'h84, rd);
      checkOutput("glitch_pend", rd, 32'h00);
      applyStimulus(pad_in_i | 8'h10);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_i);
         checkModel("level");
      end
      wbRead(8'h80, rd);
      checkOutput("level_in", rd, 32'h11);
      wbRead(8'h84, rd);
      checkOutput("level_pend", rd, 32'h10);

      // Clear racing a new rise on pad 3: the set must win
      wbWrite(8'h84, 32'hFF, 4'hF);
      wbWrite(8'h0C, 32'h0000_0100, 4'hF);
      applyStimulus(pad_in_i | 8'h08);
      wbWrite(8'h84, 32'h08, 4'hF);
      wbRead(8'h84, rd);
      checkOutput("race_pend3", rd, 32'h08);
      checkModel("race");

      // Unmapped address reads zero and ignores writes
      wbWrite(8'h90, 32'hFFFF_FFFF, 4'hF);
      wbRead(8'h90, rd);
      checkOutput("unmapped", rd, 32'd0);

      // Randomised configuration, alternate inputs and pad activity
      for (int it = 0; it < 25; it++) begin
         wbWrite(8'($urandom_range(0, NP-1) * 4), $urandom & 32'h0000_13FF, 4'($urandom));
         alt_out_i = 16'($urandom);
         alt_oe_i  = 16'($urandom);
         for (int c = 0; c < 12; c++) begin
            flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
            applyStimulus(pad_in_i ^ flip);
            checkModel("rand");
         end
         if (it % 3 == 0) begin
            wbWrite(8'h84, $urandom, 4'($urandom));
            checkModel("rand_clr");
         end
      end
      repeat (40) @(negedge clk_i);
      checkModel("settle");
      wbRead(8'h84, rd);
      checkOutput("rand_pend", rd, {24'd0, mPend});
      wbRead(8'h80, rd);
      checkOutput("rand_in", rd, {24'd0, mFilt});
      for (int p = 0; p < NP; p++) begin
         wbRead(8'(p * 4), rd);
         checkOutput("rand_cfg", rd, {16'd0, mCfg[p]});
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
